// File: rtl/spi_regfile_rx.sv
// SPI mode-0 target that deserialises 16-bit frames into the five PWM control registers.
// Register reads are returned on cipo. All SPI pins are oversampled in the clk domain.
module spi_regfile_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  localparam int NREG = 5;
  localparam int SW   = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SETTLE_N = SW'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, HOLD} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic [SW-1:0]          settle_q;
  logic                   fresh_q;

  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        rd_q, rd_d;
  logic        cipo_q, cipo_d;
  logic        err_q, err_d;
  logic [7:0]  regs_q [NREG];
  logic [7:0]  regs_d [NREG];

  logic       sclk_s, copi_s, ncs_s;
  logic       sclk_rise, sclk_fall, ncs_rise;
  logic       settled;
  logic [6:0] rd_addr;
  logic [7:0] rd_sel;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign settled   = (settle_q == SETTLE_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      settle_q    <= '0;
      fresh_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      if (!settled) settle_q <= settle_q + SW'(1);
      // Until ncs is seen high once after reset, a low ncs belongs to an interrupted frame.
      if (settled && ncs_s) fresh_q <= 1'b0;
    end
  end

  // Read address is complete on the 8th rise: seven bits already shifted plus the live one.
  assign rd_addr = {shift_q[5:0], copi_s};

  always_comb begin
    rd_sel = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (i <= MAX_ADDR && rd_addr == 7'(i)) rd_sel = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rbuf_d  = rbuf_q;
    rd_d    = rd_q;
    cipo_d  = cipo_q;
    err_d   = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        cipo_d = 1'b0;
        if (settled && !ncs_s) begin
          if (fresh_q) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT;
            cnt_d   = 5'd0;
            rd_d    = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7 && !shift_q[6]) begin
            rd_d   = 1'b1;
            rbuf_d = rd_sel;
          end
        end else if (sclk_fall) begin
          // Counts 8..15 map to buffer bits 7..0.
          if (rd_q && cnt_q[4:3] == 2'b01) cipo_d = rbuf_q[~cnt_q[2:0]];
          else                             cipo_d = 1'b0;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        cipo_d  = 1'b0;
        if (cnt_q == 5'd16) begin
          if (shift_q[15]) begin
            for (int i = 0; i < NREG; i++) begin
              if (i <= MAX_ADDR && shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
      HOLD: begin
        cipo_d = 1'b0;
        if (ncs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      shift_q <= 16'h0000;
      rbuf_q  <= 8'h00;
      rd_q    <= 1'b0;
      cipo_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rbuf_q  <= rbuf_d;
      rd_q    <= rd_d;
      cipo_q  <= cipo_d;
      err_q   <= err_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign cipo            = cipo_q;
  assign cipo_oe         = ~ncs_s & (state_q == SHIFT);
  assign frame_err       = err_q;
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_regfile_rx.sv
// Directed bench for spi_regfile_rx: SPI frames bit-banged on the pins, expected values hand-derived.
module tb_spi_regfile_rx;

  localparam int SYNC = 2;
  localparam int H    = 5;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic       cipo, cipo_oe, frame_err;
  logic [7:0] r0, r1, r2, r3, r4;

  int         n_vec    = 0;
  int         n_err    = 0;
  int         err_seen = 0;
  logic       oe_all;
  logic [7:0] rd_byte;

  spi_regfile_rx #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .frame_err(frame_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, ".r0"}, 32'(r0), 32'(e0));
    check({tag, ".r1"}, 32'(r1), 32'(e1));
    check({tag, ".r2"}, 32'(r2), 32'(e2));
    check({tag, ".r3"}, 32'(r3), 32'(e3));
    check({tag, ".r4"}, 32'(r4), 32'(e4));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: bits first_k..last_k of an nbits-long MSB-first word
  task automatic send_bits(input logic [31:0] w, input int nbits, input int first_k, input int last_k);
    for (int k = first_k; k <= last_k; k++) begin
      copi = w[nbits-k];
      wait_clk(H);
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
      wait_clk(H);
      if (k >= 8 && k <= 15) rd_byte[15-k] = cipo;
      oe_all = oe_all & cipo_oe;
    end
  endtask

  // full frame; returns SYNC+3 clk edges after ncs rises
  task automatic frame(input logic [31:0] w, input int nbits);
    err_seen = 0;
    rd_byte  = 8'h00;
    oe_all   = 1'b1;
    ncs      = 1'b0;
    wait_clk(H);
    send_bits(w, nbits, 1, nbits);
    ncs = 1'b1;
    repeat (SYNC + 3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    wait_clk(4);
    check_regs("in_reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("in_reset.cipo", 32'(cipo), 32'd0);
    rst_n = 1'b1;
    wait_clk(6);
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset.cipo_oe", 32'(cipo_oe), 32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);

    frame(32'h80F0, 16);
    check_regs("wr0", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_clk(10);
    check("wr0.err", 32'(err_seen), 32'd0);

    frame(32'h8480, 16);
    check_regs("wr4", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    wait_clk(10);
    check("wr4.err", 32'(err_seen), 32'd0);

    frame(32'h85AA, 16);
    check_regs("wr5", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    wait_clk(10);
    check("wr5.err", 32'(err_seen), 32'd0);

    frame(32'h82A, 12);
    check_regs("short", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    wait_clk(10);
    check("short.err", 32'(err_seen), 32'd1);

    frame(32'h82ABC, 20);
    check_regs("long", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h80);
    wait_clk(10);
    check("long.err", 32'(err_seen), 32'd1);

    frame(32'h835C, 16);
    check_regs("wr3", 8'hF0, 8'h00, 8'h00, 8'h5C, 8'h80);
    wait_clk(10);

    frame(32'h0300, 16);
    check("rd3.cipo_bits", 32'(rd_byte), 32'h5C);
    check("rd3.oe_in_frame", 32'(oe_all), 32'd1);
    check("rd3.oe_after", 32'(cipo_oe), 32'd0);
    check_regs("rd3", 8'hF0, 8'h00, 8'h00, 8'h5C, 8'h80);
    wait_clk(10);
    check("rd3.err", 32'(err_seen), 32'd0);
    check("rd3.cipo_idle", 32'(cipo), 32'd0);

    // reset mid-frame with ncs held low, then finish the frame
    err_seen = 0;
    oe_all   = 1'b1;
    ncs      = 1'b0;
    wait_clk(H);
    send_bits(32'h8277, 16, 1, 6);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    send_bits(32'h8277, 16, 7, 16);
    ncs = 1'b1;
    wait_clk(SYNC + 3 + 10);
    check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("midrst.err", 32'(err_seen), 32'd0);

    frame(32'h813C, 16);
    check_regs("wr1", 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00);
    wait_clk(10);
    check("wr1.err", 32'(err_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_regfile_rx.md
Name: spi_regfile_rx

Overview:
SPI mode-0 target that sits directly upstream of pwm_peripheral. It samples SCLK/COPI/nCS from ui_in pins into the system clock domain and deserialises 16-bit frames. It commits writes to the five PWM control registers and returns register contents on CIPO for read frames. Its outputs drive en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle of the PWM stage.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, copi and ncs (minimum 2).
MAX_ADDR, 4, highest valid register address; higher addresses are ignored.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, asynchronous to clk
copi  input  1  SPI data in, asynchronous to clk
ncs  input  1  SPI chip select, active low, asynchronous to clk
cipo  output  1  SPI read data out
cipo_oe  output  1  cipo output enable
en_reg_out_7_0  output  8  register addr 0x00
en_reg_out_15_8  output  8  register addr 0x01
en_reg_pwm_7_0  output  8  register addr 0x02
en_reg_pwm_15_8  output  8  register addr 0x03
pwm_duty_cycle  output  8  register addr 0x04
frame_err  output  1  one-clk pulse on a rejected frame

Behaviour:
- Reset (rst_n low, asynchronous): all five registers = 0x00; cipo = 0; cipo_oe = 0; frame_err = 0; synchronisers cleared to sclk=0, copi=0, ncs=1; FSM = IDLE; bit counter = 0.
- Synchronisation: every input passes through SYNC_STAGES flops, then one history flop for edge detection. Rising and falling edges are evaluated only on synchronised signals.
- Timing constraint: SCLK high and low phases are each ≥ SYNC_STAGES+1 clk periods.
- Frame format (MSB first, COPI sampled on SCLK rising edge):
  - bit15 = R/W (1 = write, 0 = read)
  - bits14:8 = address
  - bits7:0 = data (ignored for reads)
- FSM states:
  - IDLE: wait for synced ncs falling edge, then go to SHIFT and clear the counter.
  - SHIFT: each synced sclk rise shifts copi into a 16-bit shift register and increments the 5-bit counter. The counter saturates at 17.
  - COMMIT: entered on synced ncs rising edge from SHIFT. Lasts one clk, then returns to IDLE.
  - HOLD: entered when reset releases while synced ncs is low. The FSM stays in HOLD until ncs rises, so no partial frame is ever accepted.
- Commit rules (evaluated in COMMIT):
  - count == 16 AND R/W == 1 AND address ≤ MAX_ADDR: the addressed register loads data. The new value is visible at the clk edge ending COMMIT.
  - count == 16 AND R/W == 1 AND address > MAX_ADDR: no write, no error.
  - count ≠ 16 (short or long frame): no write; frame_err pulses high for exactly one clk.
  - R/W == 0 with count == 16: no write, no error.
- Commit latency: registers update no later than SYNC_STAGES+3 clk edges after ncs rises at the pin.
- Read path:
  - On the 8th synced sclk rise with R/W = 0, the addressed register is latched into an 8-bit read buffer. An invalid address latches 0x00.
  - On each subsequent synced sclk fall, while count is 8..15, cipo drives the next buffer bit, starting at bit7.
  - cipo = 0 at all other times.
- cipo_oe = NOT synced ncs. It is 0 in IDLE and HOLD.
- ncs falling edge while in SHIFT cannot occur; a new ncs falling edge seen in COMMIT is honoured on the next IDLE cycle. Back-to-back frames separated by ≥ SYNC_STAGES+2 clk of ncs high are all accepted.
- sclk edges while synced ncs is high are ignored. The counter does not advance.
- No register is ever partially updated; only one register changes per frame.

Test Plan:
- Reset: hold rst_n low, then release → all five registers 0x00, cipo_oe 0, frame_err 0.
- Write 0x80,0xF0 (addr 0x00, data 0xF0), then write 0x84,0x80 → en_reg_out_7_0 = 0xF0 and pwm_duty_cycle = 0x80 within SYNC_STAGES+3 clk of each ncs rise; all other registers stay 0x00.
- Write 0x85,0xAA (addr 0x05 > MAX_ADDR) → no register changes, frame_err stays 0.
- 12-bit frame (write, addr 0x02, ncs raised early), then 20-bit frame → en_reg_pwm_7_0 unchanged; frame_err pulses once per frame, each pulse exactly one clk wide.
- Write 0x83,0x5C, then read frame 0x03,0x00 → cipo shifts 0,1,0,1,1,1,0,0 on SCLK falls 8..15; cipo_oe high only while ncs is low.
- Assert rst_n low mid-frame with ncs held low, release, finish the frame, then send a clean write 0x81,0x3C → the interrupted frame causes no write and no frame_err; en_reg_out_15_8 = 0x3C after the clean frame.
